dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder (target side) for the core's load/store port.
//  Accepts one request at a time over a valid/ready handshake and returns read data after a fixed access latency.
//  Stores are byte/half/word-masked; loads are sign- or zero-extended. Misaligned and out-of-range accesses return an error.
//  Sits behind the core's ALUResult/WriteData/MemWrite/MemRead signals, in place of the zero-latency data memory.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1
//  LATENCY      2    cycles from the accept edge to the rsp_valid rise; legal range 1..15
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, synchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept (high only in IDLE)
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data; bytes taken from LSBs
//  req_we     in   2   00 none, 01 sb, 10 sh, 11 sw
//  req_re     in   3   000 none, 001 lb, 010 lh, 011 lw, 100 lbu, 101 lhu; 110/111 illegal
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   requester takes response
//  rsp_rdata  out  32  extended load data; 0 for stores, nops and errors
//  rsp_err    out  1   access error (misaligned, out of range, illegal/conflicting op)
//  dm0,dm4,dm8 out 32  live contents of words at byte address 0, 4, 8 (debug)
// BEHAVIOUR
//  States: IDLE, BUSY, RESP. Reset -> IDLE, mem all zero, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//  IDLE: accept on req_valid&&req_ready; latch addr/wdata/we/re; load cnt=LATENCY-1; -> BUSY, or -> RESP directly if LATENCY=1.
//  BUSY: req_ready=0; cnt decrements each cycle; when cnt reaches 0 -> RESP. rsp_valid rises exactly LATENCY cycles after the accept edge.
//  On the edge entering RESP: evaluate errors; a legal store commits to mem; a load registers rsp_rdata from mem at that edge.
//  RESP: rsp_valid=1 with rdata/err stable until rsp_ready=1. Handshake edge -> IDLE; rsp_valid, rsp_rdata, rsp_err clear to 0.
//  No request is accepted in the cycle the response completes: back-to-back throughput is one access per LATENCY+2 cycles.
//  Single outstanding transaction. req_* inputs are ignored outside IDLE.
//  Error conditions (rsp_err=1, no mem write, rdata=0):
//   - half access (lh/lhu/sh) with addr[0]=1;
//   - word access (lw/sw) with addr[1:0]!=0;
//   - addr[31:2] >= DEPTH_WORDS;
//   - req_we!=0 and req_re!=0 in the same request;
//   - req_re = 110 or 111.
//  we=00 and re=000: nop; it still completes the handshake with err=0 and rdata=0.
//  Byte lanes are little-endian: byte lane = addr[1:0]; half lane = addr[1].
//  Loads: lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw returns the full word.
//  Stores: sb writes one lane, sh writes two lanes, sw writes four lanes; untouched lanes keep their value.
//  dm0/dm4/dm8 reflect mem combinationally and show a committed store from the cycle after the commit edge.
//  rst asserted mid-transaction (BUSY or RESP): the transaction is dropped; a store not yet committed is never written.
//   Mem is cleared; the FSM is in IDLE on the next cycle.
//  rsp_ready held high continuously: the response lasts exactly one cycle.
// TESTING
//  1. Reset, then sw addr=0x8 data=0xDEADBEEF, LATENCY=2 -> rsp_valid 2 cycles after accept; err=0; dm8=0xDEADBEEF.
//  2. After test 1: lb addr=0xB -> rdata=0xFFFFFFDE; lbu addr=0xB -> 0x000000DE; lh addr=0x8 -> 0xFFFFBEEF; lhu -> 0x0000BEEF.
//  3. sb addr=0x9 data=0x12 over word 0xDEADBEEF -> dm8=0xDEAD12EF; sh addr=0xA data=0x5678 -> dm8=0x567812EF.
//  4. lw addr=0x6 -> err=1, rdata=0; sh addr=0x5 -> err=1, dm4 unchanged; lw addr=4*DEPTH_WORDS -> err=1.
//  5. Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0; release -> IDLE next cycle.
//  6. sw addr=0x0 data=0x1, assert rst in BUSY -> dm0=0, no rsp_valid, req_ready=1 the cycle after reset releases.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store request at a time over a
// valid/ready handshake and answers after a fixed access latency.
// Stores are lane-masked and loads are sign/zero-extended. Misaligned,
// out-of-range, conflicting and illegal requests complete with rsp_err set.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_we,
  input  logic [2:0]  req_re,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dm0,
  output logic [31:0] dm4,
  output logic [31:0] dm8
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  we_q, we_d;
  logic [2:0]  re_q, re_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] op_addr, op_wdata;
  logic [1:0]  op_we;
  logic [2:0]  op_re;
  logic [IDX_W-1:0] op_idx;
  logic [31:0] cur_word, new_word, load_data, store_rep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  byte_en;
  logic        is_half, is_word, out_of_range, op_err;
  logic        enter_resp, mem_wen;

  // With LATENCY=1 the access is evaluated on the accept edge itself, so
  // the operation comes straight from the request pins while IDLE.
  always_comb begin
    op_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    op_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    op_we    = (state_q == S_IDLE) ? req_we    : we_q;
    op_re    = (state_q == S_IDLE) ? req_re    : re_q;
  end

  // Decode the selected operation: error checks, load extraction and the
  // merged word a store would write back.
  always_comb begin
    op_idx       = op_addr[IDX_W+1:2];
    cur_word     = mem_q[op_idx];
    out_of_range = (op_addr[31:2] >= 30'(DEPTH_WORDS));
    is_half      = (op_we == 2'b10) || (op_re == 3'b010) || (op_re == 3'b101);
    is_word      = (op_we == 2'b11) || (op_re == 3'b011);
    op_err       = out_of_range
                || ((op_we != 2'b00) && (op_re != 3'b000))
                || (op_re[2:1] == 2'b11)
                || (is_half && op_addr[0])
                || (is_word && (op_addr[1:0] != 2'b00));
    ld_byte = cur_word[{op_addr[1:0], 3'b000} +: 8];
    ld_half = cur_word[{op_addr[1], 4'b0000} +: 16];
    load_data = '0;
    case (op_re)
      3'b001:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b011:  load_data = cur_word;
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = '0;
    endcase
    byte_en   = 4'b0000;
    store_rep = op_wdata;
    case (op_we)
      2'b01: begin
        byte_en   = 4'b0001 << op_addr[1:0];
        store_rep = {4{op_wdata[7:0]}};
      end
      2'b10: begin
        byte_en   = op_addr[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{op_wdata[15:0]}};
      end
      2'b11:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
    new_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) new_word[8*i +: 8] = store_rep[8*i +: 8];
    end
  end

  // Next-state and handshake logic; the response is captured on the edge
  // that enters RESP and cleared on the edge that completes it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    re_d       = re_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    enter_resp = 1'b0;
    mem_wen    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          re_d    = req_re;
          cnt_d   = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = op_err;
      rdata_d = op_err ? 32'd0 : load_data;
      mem_wen = !op_err && (op_we != 2'b00);
    end
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      re_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array; reset wins over a pending commit so a dropped store is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (mem_wen) begin
      mem_q[op_idx] <= new_word;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dm0       = mem_q[0];
  assign dm4       = mem_q[1];
  assign dm8       = mem_q[2];

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a byte-array reference model
// predicts each response, a scoreboard queue holds the predictions and a
// separate monitor compares whatever the DUT presents.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_we;
  logic [2:0]  req_re;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata, dm0, dm4, dm8;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  refMem [4*DEPTH];
  int          nChecks = 0;
  int          nPass   = 0;
  int          cycle   = 0;
  int          readyMode = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_we(req_we), .req_re(req_re),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dm0(dm0), .dm4(dm4), .dm8(dm8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Requester side of the response channel.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got === want) nPass++;
    else $display("[TB] FAIL %s: got=%h want=%h", name, got, want);
  endtask

  function automatic logic [31:0] refWord(input int k);
    return {refMem[4*k+3], refMem[4*k+2], refMem[4*k+1], refMem[4*k]};
  endfunction

  // Reference behaviour straight from the access rules, on a byte array.
  function automatic void refAccess(input logic [1:0] we, input logic [2:0] re,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    output logic [31:0] rd, output logic er);
    int size;
    logic [31:0] v;
    rd = '0;
    er = 1'b0;
    v  = '0;
    case (we)
      2'd1: size = 1;
      2'd2: size = 2;
      2'd3: size = 4;
      default: size = 0;
    endcase
    if (we == 2'd0) begin
      case (re)
        3'd1, 3'd4: size = 1;
        3'd2, 3'd5: size = 2;
        3'd3:       size = 4;
        default:    size = 0;
      endcase
    end
    if (we != 0 && re != 0) er = 1'b1;
    if (re == 3'd6 || re == 3'd7) er = 1'b1;
    if ((addr >> 2) >= DEPTH) er = 1'b1;
    if (size > 1 && (addr % size) != 0) er = 1'b1;
    if (!er) begin
      if (we != 0) begin
        for (int i = 0; i < size; i++) refMem[addr + i] = wdata[8*i +: 8];
      end else if (size > 0) begin
        for (int i = 0; i < size; i++) v = v | (32'(refMem[addr + i]) << (8*i));
        if (re == 3'd1 && v[7])  v = v | 32'hFFFF_FF00;
        if (re == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endfunction

  task automatic applyStimulus(input logic [1:0] we, input logic [2:0] re,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input bit expectRsp);
    exp_t e;
    int t;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_re    = re;
    req_addr  = addr;
    req_wdata = wdata;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      nChecks++;
      $display("[TB] FAIL accept_timeout: got req_ready=0 want 1 within 100 cycles");
      req_valid = 1'b0;
      return;
    end
    if (expectRsp) begin
      refAccess(we, re, addr, wdata, e.rdata, e.err);
      e.acc = cycle + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_we    = 2'($urandom);
    req_re    = 3'($urandom);
  endtask

  task automatic checkDm(input string tag);
    checkOutput({tag, "_dm0"}, dm0, refWord(0));
    checkOutput({tag, "_dm4"}, dm4, refWord(1));
    checkOutput({tag, "_dm8"}, dm8, refWord(2));
  endtask

  task automatic waitDone();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      nChecks++;
      $display("[TB] FAIL rsp_timeout: got %0d pending responses want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    bit seen, hsPrev;
    seen = 0;
    hsPrev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0;
        hsPrev = 0;
      end else begin
        if (hsPrev) checkOutput("req_ready_after_rsp", 32'(req_ready), 32'd1);
        hsPrev = 0;
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            nChecks++;
            $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 want 0 (no request pending)");
          end else begin
            if (!seen) begin
              checkOutput("latency", 32'(cycle - sb[0].acc), 32'(LAT));
              seen = 1;
            end
            checkOutput("rdata", rsp_rdata, sb[0].rdata);
            checkOutput("err", 32'(rsp_err), 32'(sb[0].err));
            checkOutput("req_ready_in_resp", 32'(req_ready), 32'd0);
            if (rsp_ready) begin
              void'(sb.pop_front());
              seen = 0;
              hsPrev = 1;
            end
          end
        end else begin
          checkOutput("idle_rdata", rsp_rdata, 32'd0);
          checkOutput("idle_err", 32'(rsp_err), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  we;
    logic [2:0]  re;
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_we = '0;
    req_re = '0;
    for (int i = 0; i < 4*DEPTH; i++) refMem[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_err", 32'(rsp_err), 32'd0);
    checkDm("reset");

    $display("[TB] word store and extended loads");
    applyStimulus(2'b11, 3'b000, 32'h8, 32'hDEADBEEF, 1);
    waitDone();
    checkOutput("t1_dm8", dm8, 32'hDEADBEEF);
    applyStimulus(2'b00, 3'b001, 32'hB, 32'h0, 1);
    applyStimulus(2'b00, 3'b100, 32'hB, 32'h0, 1);
    applyStimulus(2'b00, 3'b010, 32'h8, 32'h0, 1);
    applyStimulus(2'b00, 3'b101, 32'h8, 32'h0, 1);
    waitDone();

    $display("[TB] partial stores");
    applyStimulus(2'b01, 3'b000, 32'h9, 32'hFFFFFF12, 1);
    waitDone();
    checkOutput("t3_dm8_sb", dm8, 32'hDEAD12EF);
    applyStimulus(2'b10, 3'b000, 32'hA, 32'hAAAA5678, 1);
    waitDone();
    checkOutput("t3_dm8_sh", dm8, 32'h567812EF);

    $display("[TB] error cases and nop");
    applyStimulus(2'b00, 3'b011, 32'h6, 32'h0, 1);
    applyStimulus(2'b10, 3'b000, 32'h5, 32'h1234, 1);
    applyStimulus(2'b00, 3'b011, 32'(4*DEPTH), 32'h0, 1);
    applyStimulus(2'b11, 3'b011, 32'h0, 32'h55, 1);
    applyStimulus(2'b00, 3'b110, 32'h4, 32'h0, 1);
    applyStimulus(2'b00, 3'b000, 32'h4, 32'h0, 1);
    waitDone();
    checkOutput("t4_dm4", dm4, 32'h0);
    checkDm("errors");

    $display("[TB] response backpressure");
    readyMode = 2;
    applyStimulus(2'b00, 3'b011, 32'h8, 32'h0, 1);
    repeat (LAT + 5) @(negedge clk);
    checkOutput("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
    readyMode = 0;
    waitDone();

    $display("[TB] randomized traffic");
    readyMode = 1;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 15));
      else a = 32'($urandom_range(0, 4*DEPTH - 1));
      if ($urandom_range(0, 9) < 8) begin
        if ($urandom_range(0, 1) == 0) begin
          we = 2'($urandom_range(1, 3));
          re = 3'd0;
        end else begin
          we = 2'd0;
          re = 3'($urandom_range(1, 5));
        end
      end else begin
        we = 2'($urandom);
        re = 3'($urandom);
      end
      applyStimulus(we, re, a, $urandom, 1);
    end
    readyMode = 0;
    waitDone();
    checkDm("random");

    $display("[TB] reset during busy");
    applyStimulus(2'b11, 3'b000, 32'h0, 32'h1, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4*DEPTH; i++) refMem[i] = 8'h00;
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkDm("rst_busy");
    repeat (LAT + 2) @(negedge clk);
    checkOutput("rst_no_late_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("rst_dm0", dm0, 32'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
